// File: rtl/exc_commit_pkg.sv
// Shared WB/CP0 definitions for exc_commit: bus width, exception codes, CP0 addresses,
// exception vector and the WB-to-CP0 bus layout.
package exc_commit_pkg;

  localparam int unsigned WB_TO_CP0_REGISTER_BUS_WD = 110;
  localparam int unsigned EXCODE_W = 5;
  localparam int unsigned C0_ADDR_W = 5;
  localparam int unsigned XLEN = 32;

  localparam logic [EXCODE_W-1:0] EX_INT  = 5'h00;
  localparam logic [EXCODE_W-1:0] EX_ADEL = 5'h04;
  localparam logic [EXCODE_W-1:0] EX_ADES = 5'h05;
  localparam logic [EXCODE_W-1:0] EX_SYS  = 5'h08;
  localparam logic [EXCODE_W-1:0] EX_BP   = 5'h09;
  localparam logic [EXCODE_W-1:0] EX_RI   = 5'h0a;
  localparam logic [EXCODE_W-1:0] EX_OV   = 5'h0c;

  localparam logic [C0_ADDR_W-1:0] CR_BADVADDR = 5'd8;
  localparam logic [C0_ADDR_W-1:0] CR_COUNT    = 5'd9;
  localparam logic [C0_ADDR_W-1:0] CR_COMPARE  = 5'd11;
  localparam logic [C0_ADDR_W-1:0] CR_STATUS   = 5'd12;
  localparam logic [C0_ADDR_W-1:0] CR_CAUSE    = 5'd13;
  localparam logic [C0_ADDR_W-1:0] CR_EPC      = 5'd14;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC00380;

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  // Fields MSB-first as seen by CP0.
  typedef struct packed {
    logic                 ex;
    logic [EXCODE_W-1:0]  excode;
    logic [XLEN-1:0]      badvaddr;
    logic                 bd;
    logic [XLEN-1:0]      pc;
    logic                 mtc0_we;
    logic [C0_ADDR_W-1:0] c0_waddr;
    logic [XLEN-1:0]      c0_wdata;
    logic                 eret_flush;
  } wb_bus_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic                 bd;
    logic                 ex;
    logic [EXCODE_W-1:0]  excode;
    logic [XLEN-1:0]      badvaddr;
    logic                 mtc0;
    logic                 eret;
    logic [C0_ADDR_W-1:0] c0_addr;
    logic [XLEN-1:0]      c0_wdata;
  } wb_reg_t;

  function automatic logic keeps_badvaddr(input logic [EXCODE_W-1:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

endpackage

// File: rtl/exc_commit.sv
// WB-stage exception/eret commit: holds the retiring instruction, drives the CP0 bus and
// the pipeline flush/redirect. Optional interrupt sampling enabled by macro EXC_COMMIT_INT_EN.
module exc_commit
  import exc_commit_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ms_to_ws_valid,
  output logic                                 ws_allowin,
  input  logic [XLEN-1:0]                      ms_pc,
  input  logic                                 ms_bd,
  input  logic                                 ms_ex,
  input  logic [EXCODE_W-1:0]                  ms_excode,
  input  logic [XLEN-1:0]                      ms_badvaddr,
  input  logic                                 ms_mtc0,
  input  logic                                 ms_eret,
  input  logic [C0_ADDR_W-1:0]                 ms_c0_addr,
  input  logic [XLEN-1:0]                      ms_c0_wdata,
  input  logic                                 c0_status_ie,
  input  logic                                 c0_status_exl,
  input  logic [7:0]                           c0_status_im,
  input  logic [7:0]                           c0_cause_ip,
  input  logic [XLEN-1:0]                      c0_epc,
  output logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
  output logic                                 ws_flush,
  output logic [XLEN-1:0]                      ws_flush_pc,
  output logic                                 ws_valid
);

  state_t  state;
  state_t  state_nxt;
  wb_reg_t wb;
  logic    valid_r;
  logic    load;
  logic    int_pending;
  wb_bus_t bus;

`ifdef EXC_COMMIT_INT_EN
  assign int_pending = c0_status_ie && !c0_status_exl && |(c0_status_im & c0_cause_ip);
`else
  logic unused_int;
  assign unused_int  = ^{c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip};
  assign int_pending = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // FLUSH lasts exactly one cycle after the flushing instruction commits.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (ws_flush) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    ws_allowin = 1'b0;
    if (state == S_RUN) ws_allowin = 1'b1;
  end

  assign load = ms_to_ws_valid && ws_allowin;

  // An instruction loaded in the flush cycle is discarded by the FLUSH gating below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      wb      <= '0;
    end else begin
      valid_r <= load;
      if (load) begin
        wb.pc       <= ms_pc;
        wb.bd       <= ms_bd;
        wb.ex       <= ms_ex || int_pending;
        wb.excode   <= int_pending ? EX_INT : ms_excode;
        wb.badvaddr <= ms_badvaddr;
        wb.mtc0     <= ms_mtc0;
        wb.eret     <= ms_eret;
        wb.c0_addr  <= ms_c0_addr;
        wb.c0_wdata <= ms_c0_wdata;
      end
    end
  end

  assign ws_valid = valid_r && (state == S_RUN);

  always_comb begin
    bus            = '0;
    bus.ex         = ws_valid && wb.ex;
    bus.excode     = wb.excode;
    bus.badvaddr   = keeps_badvaddr(wb.excode) ? wb.badvaddr : '0;
    bus.bd         = wb.bd;
    bus.pc         = wb.pc;
    bus.mtc0_we    = ws_valid && wb.mtc0 && !wb.ex;
    bus.c0_waddr   = wb.c0_addr;
    bus.c0_wdata   = wb.c0_wdata;
    bus.eret_flush = ws_valid && wb.eret && !wb.ex;
  end

  assign wb_to_cp0_register_bus = bus;
  assign ws_flush               = bus.ex || bus.eret_flush;

  // Exception wins over eret when both are flagged.
  always_comb begin
    ws_flush_pc = '0;
    if (bus.ex)              ws_flush_pc = EXC_VECTOR;
    else if (bus.eret_flush) ws_flush_pc = c0_epc;
  end

endmodule

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: directed corner cases plus random traffic against a
// transaction-level model of commit, flush and drop behaviour.
module tb_exc_commit;
  import exc_commit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_bd;
  logic        ms_ex;
  logic [4:0]  ms_excode;
  logic [31:0] ms_badvaddr;
  logic        ms_mtc0;
  logic        ms_eret;
  logic [4:0]  ms_c0_addr;
  logic [31:0] ms_c0_wdata;
  logic        c0_status_ie;
  logic        c0_status_exl;
  logic [7:0]  c0_status_im;
  logic [7:0]  c0_cause_ip;
  logic [31:0] c0_epc;
  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus;
  logic        ws_flush;
  logic [31:0] ws_flush_pc;
  logic        ws_valid;
  wb_bus_t     obus;

  always #5 clk = ~clk;
  assign obus = wb_to_cp0_register_bus;

  exc_commit dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode),
    .ms_badvaddr(ms_badvaddr), .ms_mtc0(ms_mtc0), .ms_eret(ms_eret),
    .ms_c0_addr(ms_c0_addr), .ms_c0_wdata(ms_c0_wdata),
    .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
    .wb_to_cp0_register_bus(wb_to_cp0_register_bus),
    .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .ws_valid(ws_valid)
  );

  typedef struct {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
    logic        mtc0_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        eret_flush;
    logic        flush;
    logic [31:0] flush_pc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   exp_valid = 1'b0;
  bit   exp_allowin = 1'b1;
  bit   m_in_flush = 1'b0;
  bit   m_flush_now = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural outcome of one instruction as it commits.
  function automatic exp_t predict(input logic [31:0] pc, input logic bd, input logic exc,
                                   input logic [4:0] code, input logic [31:0] badv,
                                   input logic mtc0, input logic eret, input logic [4:0] addr,
                                   input logic [31:0] wdata, input logic ie, input logic exl,
                                   input logic [7:0] im, input logic [7:0] ip,
                                   input logic [31:0] epc);
    exp_t e;
    logic int_p;
`ifdef EXC_COMMIT_INT_EN
    int_p = ie && !exl && ((im & ip) != 8'h00);
`else
    int_p = ie & exl & (|(im & ip)) & 1'b0;
`endif
    e.ex         = int_p || exc;
    e.excode     = int_p ? 5'h00 : code;
    e.badvaddr   = (e.excode == 5'h04 || e.excode == 5'h05) ? badv : 32'h0;
    e.bd         = bd;
    e.pc         = pc;
    e.mtc0_we    = mtc0 && !e.ex;
    e.waddr      = addr;
    e.wdata      = wdata;
    e.eret_flush = eret && !e.ex;
    e.flush      = e.ex || e.eret_flush;
    e.flush_pc   = e.ex ? 32'hBFC00380 : (e.eret_flush ? epc : 32'h0);
    return e;
  endfunction

  // Drive one MEM-stage offer for the next edge and advance the model by one cycle.
  task automatic offer(input logic v, input logic [31:0] pc, input logic bd, input logic exc,
                       input logic [4:0] code, input logic [31:0] badv, input logic mtc0,
                       input logic eret, input logic [4:0] addr, input logic [31:0] wdata,
                       input logic ie, input logic exl, input logic [7:0] im,
                       input logic [7:0] ip);
    bit appears;
    exp_t e;
    ms_to_ws_valid = v;   ms_pc = pc;       ms_bd = bd;       ms_ex = exc;
    ms_excode = code;     ms_badvaddr = badv; ms_mtc0 = mtc0; ms_eret = eret;
    ms_c0_addr = addr;    ms_c0_wdata = wdata;
    c0_status_ie = ie;    c0_status_exl = exl; c0_status_im = im; c0_cause_ip = ip;
    // Accepted only outside FLUSH, and survives only if the current instruction does not flush.
    appears = v && !m_in_flush && !m_flush_now;
    m_in_flush = m_flush_now;
    m_flush_now = 1'b0;
    if (appears) begin
      e = predict(pc, bd, exc, code, badv, mtc0, eret, addr, wdata, ie, exl, im, ip, c0_epc);
      q.push_back(e);
      m_flush_now = e.flush;
    end
    exp_valid = appears;
    exp_allowin = !m_in_flush;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    offer(1'b0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
  endtask

  task automatic rand_offer();
    logic [4:0] code;
    case ($urandom_range(4))
      0: code = 5'h04;
      1: code = 5'h05;
      2: code = 5'h08;
      3: code = 5'h0c;
      default: code = 5'($urandom);
    endcase
    offer($urandom_range(3) != 0, $urandom, 1'($urandom), $urandom_range(3) == 0, code,
          $urandom, $urandom_range(3) == 0, $urandom_range(7) == 0, 5'($urandom), $urandom,
          1'($urandom), 1'($urandom), 8'($urandom),
          ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00);
  endtask

  // Monitor: pops the scoreboard whenever an instruction is expected on the bus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("allowin", 32'(ws_allowin), 32'(exp_allowin));
        chk("valid", 32'(ws_valid), 32'(exp_valid));
        if (exp_valid) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: empty queue, expected a pending instruction");
          end else begin
            e = q.pop_front();
            chk("ex", 32'(obus.ex), 32'(e.ex));
            chk("excode", 32'(obus.excode), 32'(e.excode));
            chk("badvaddr", obus.badvaddr, e.badvaddr);
            chk("bd", 32'(obus.bd), 32'(e.bd));
            chk("pc", obus.pc, e.pc);
            chk("mtc0_we", 32'(obus.mtc0_we), 32'(e.mtc0_we));
            chk("c0_waddr", 32'(obus.c0_waddr), 32'(e.waddr));
            chk("c0_wdata", obus.c0_wdata, e.wdata);
            chk("eret_flush", 32'(obus.eret_flush), 32'(e.eret_flush));
            chk("ws_flush", 32'(ws_flush), 32'(e.flush));
            chk("ws_flush_pc", ws_flush_pc, e.flush_pc);
          end
        end else begin
          chk("idle_flush", 32'(ws_flush), 32'h0);
          chk("idle_ex", 32'(obus.ex), 32'h0);
          chk("idle_mtc0_we", 32'(obus.mtc0_we), 32'h0);
          chk("idle_eret", 32'(obus.eret_flush), 32'h0);
          chk("idle_flush_pc", ws_flush_pc, 32'h0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    c0_epc = 32'h0;
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_bd = 1'b0; ms_ex = 1'b0; ms_excode = '0;
    ms_badvaddr = '0; ms_mtc0 = 1'b0; ms_eret = 1'b0; ms_c0_addr = '0; ms_c0_wdata = '0;
    c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_im = '0; c0_cause_ip = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ws_valid), 32'h0);
    chk("rst_allowin", 32'(ws_allowin), 32'h1);
    chk("rst_flush", 32'(ws_flush), 32'h0);
    chk("rst_flush_pc", ws_flush_pc, 32'h0);
    chk("rst_bus_nonzero", 32'(wb_to_cp0_register_bus != '0), 32'h0);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Address-error load: badvaddr kept, vector redirect, then one FLUSH cycle.
    offer(1'b1, 32'hBFC00010, 1'b0, 1'b1, 5'h04, 32'h1234, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
    idle(); idle();
    // Overflow code hides badvaddr.
    offer(1'b1, 32'hBFC00020, 1'b1, 1'b1, 5'h0c, 32'hDEAD, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
    idle(); idle();
    // Eret to EPC; instructions offered in the flush cycle and during FLUSH are dropped.
    c0_epc = 32'hBFC00100;
    offer(1'b1, 32'hBFC00030, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b1, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
    offer(1'b1, 32'hBFC00034, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 5'd12, 32'hAAAA5555, 1'b0, 1'b0, 8'h0, 8'h0);
    offer(1'b1, 32'hBFC00038, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 5'd14, 32'h5555AAAA, 1'b0, 1'b0, 8'h0, 8'h0);
    idle();
    offer(1'b1, 32'hBFC00040, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 5'd13, 32'h00000300, 1'b0, 1'b0, 8'h0, 8'h0);
    idle(); idle();
    // Pending interrupt against an mtc0 (outcome depends on the build option).
    offer(1'b1, 32'hBFC00050, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 5'd12, 32'h12345678, 1'b1, 1'b0, 8'h80, 8'h80);
    idle(); idle();
    // Syscall together with eret: exception wins.
    offer(1'b1, 32'hBFC00060, 1'b0, 1'b1, 5'h08, 32'h0, 1'b0, 1'b1, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
    idle(); idle();

    c0_epc = $urandom;
    repeat (600) rand_offer();
    idle(); idle();
    chk("queue_drained", 32'(q.size()), 32'h0);

    // Reset while in FLUSH with a dropped instruction still latched.
    offer(1'b1, 32'hBFC00070, 1'b0, 1'b1, 5'h0a, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0);
    offer(1'b1, 32'hBFC00074, 1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h1, 1'b0, 1'b0, 8'h0, 8'h0);
    mon_en = 1'b0;
    chk("flush_state_allowin", 32'(ws_allowin), 32'h0);
    reset = 1'b1;
    #1;
    chk("midflush_rst_valid", 32'(ws_valid), 32'h0);
    chk("midflush_rst_flush", 32'(ws_flush), 32'h0);
    chk("midflush_rst_allowin", 32'(ws_allowin), 32'h1);
    chk("midflush_rst_bus", 32'(wb_to_cp0_register_bus != '0), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    m_in_flush = 1'b0;
    m_flush_now = 1'b0;
    exp_valid = 1'b0;
    exp_allowin = 1'b1;
    mon_en = 1'b1;
    repeat (40) rand_offer();
    idle(); idle();
    chk("queue_drained_end", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ms_to_ws_valid  in  1  MEM-stage instruction valid; ws_allowin  out  1  WB may accept.
REQ-003 SHALL have ms_pc  in  32; ms_bd  in  1  delay slot; ms_ex  in  1; ms_excode  in  5; ms_badvaddr  in  32.
REQ-004 SHALL have ms_mtc0  in  1; ms_eret  in  1; ms_c0_addr  in  5; ms_c0_wdata  in  32.
REQ-005 SHALL have c0_status_ie  in  1; c0_status_exl  in  1; c0_status_im  in  8; c0_cause_ip  in  8; c0_epc  in  32.
REQ-006 SHALL have wb_to_cp0_register_bus  out  WB_TO_CP0_REGISTER_BUS_WD (110)  fields MSB-first: ex, excode[4:0], badvaddr[31:0], bd, pc[31:0], mtc0_we, c0_waddr[4:0], c0_wdata[31:0], eret_flush.
REQ-007 SHALL have ws_flush  out  1  pipeline flush pulse; ws_flush_pc  out  32  redirect target; ws_valid  out  1.

Function
REQ-008 SHALL hold one WB register (pc, bd, ex, excode, badvaddr, mtc0, eret, addr, wdata) loaded when ms_to_ws_valid && ws_allowin.
REQ-009 SHALL clear ws_valid when ws_allowin && !ms_to_ws_valid.
REQ-010 SHALL implement FSM RUN/FLUSH; RUN: ws_allowin=1; FLUSH: ws_allowin=0, ws_valid forced 0, incoming ms data dropped.
REQ-011 SHALL transition RUN->FLUSH on the cycle ws_flush=1; FLUSH->RUN unconditionally after one cycle.
REQ-012 SHALL compute int_pending = c0_status_ie && !c0_status_exl && |(c0_status_im & c0_cause_ip), sampled at load time.
REQ-013 SHALL, when int_pending at load, store ex=1, excode=0x00 (INT), overriding any ms exception.
REQ-014 SHALL drive bus ex = ws_valid && ex_r; excode, bd, pc from WB register.
REQ-015 SHALL drive bus badvaddr = stored value only when excode is 0x04 (ADEL) or 0x05 (ADES), else 0.
REQ-016 SHALL drive mtc0_we = ws_valid && mtc0_r && !ex_r; eret_flush = ws_valid && eret_r && !ex_r.
REQ-017 SHALL assert ws_flush combinationally in the same cycle as bus ex or eret_flush.
REQ-018 SHALL drive ws_flush_pc = 0xBFC00380 on exception, c0_epc on eret, 0 otherwise.
REQ-019 SHALL give exception priority over eret and mtc0 in the same instruction.

Reset
REQ-020 SHALL on reset (any time, incl. mid-FLUSH): FSM=RUN, ws_valid=0, all WB register fields 0.
REQ-021 SHALL hold all outputs 0 during reset except ws_allowin=1.

Configuration
REQ-022 SHALL honour macro EXC_COMMIT_INT_EN: defined -> REQ-012/013 active; undefined -> int_pending tied 0, c0_status_im/c0_cause_ip/c0_status_ie unused, no INT excode ever produced.

Structure
REQ-023 SHALL take WB_TO_CP0_REGISTER_BUS_WD, EX_* excode constants and CR_* addresses from shared header mycpu.h; exception vector 0xBFC00380 added there as EXC_VECTOR.
REQ-024 SHALL be a single module; no sub-module.

Verification
REQ-025 SHALL cover: ms_ex=1 excode=0x04 badvaddr=0x1234 pc=0xBFC00010 -> ex=1, badvaddr=0x1234, ws_flush=1, flush_pc=0xBFC00380, next cycle ws_allowin=0.
REQ-026 SHALL cover: ms_eret=1, c0_epc=0xBFC00100 -> eret_flush=1, flush_pc=0xBFC00100, FLUSH one cycle, instruction offered during FLUSH never appears on bus.
REQ-027 SHALL cover: ie=1 exl=0 im=0x80 ip=0x80, ms_mtc0=1 -> ex=1 excode=0, mtc0_we=0; same with EXC_COMMIT_INT_EN undefined -> mtc0_we=1, ex=0.
REQ-028 SHALL cover: ms_ex=1 excode=0x08 with ms_eret=1 -> ex=1, eret_flush=0, flush_pc=0xBFC00380.
REQ-029 SHALL cover: reset asserted in FLUSH -> immediately ws_valid=0, ws_flush=0, ws_allowin=1.
REQ-030 SHALL cover: excode=0x0C with ms_badvaddr=0xDEAD -> bus badvaddr=0.
